// File: rtl/vgacon_term_ctrl.sv
// vgacon_term_ctrl
//   Terminal-style sequencer for the VGA console text buffer. Takes a
//   character stream, keeps a cursor and interprets CR/LF/BS/FF. It scrolls
//   and clears the screen by reading and rewriting the buffer. It shares the
//   buffer's single write port with direct host writes. Host writes always
//   win. Sequencer writes happen only during blanking.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   ch_valid/ch_ready/ch_data  character stream, {color_sel, code[6:0]}
//   host_we/addr/wdata       direct host write (never blocked)
//   blank                    VGA blanking interval
//   buf_we/addr/wdata        text buffer write port
//   buf_raddr/buf_rdata      text buffer combinational read port
//   cursor_row/cursor_col    cursor position
//   busy                     sequencer is working on a write sequence
module vgacon_term_ctrl #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ch_valid,
    input  logic [7:0] ch_data,
    output logic       ch_ready,
    input  logic       host_we,
    input  logic [4:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic       blank,
    output logic       buf_we,
    output logic [4:0] buf_addr,
    output logic [7:0] buf_wdata,
    output logic [4:0] buf_raddr,
    input  logic [7:0] buf_rdata,
    output logic [1:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic       busy
);
    localparam int LAST_CELL = NUM_ROWS * NUM_COLS - 1;
    localparam int LAST_COPY = (NUM_ROWS - 1) * NUM_COLS - 1;

    typedef enum logic [2:0] {IDLE, PUT, SCROLL_COPY, SCROLL_CLEAR, CLEAR} state_t;

    state_t     state, state_n;
    logic [1:0] row, row_n;
    logic [3:0] col, col_n;
    logic [4:0] idx, idx_n;
    logic [7:0] data_q, data_n;

    logic [4:0] cur_addr, seq_addr;
    logic [7:0] seq_data;
    logic [6:0] code;
    logic       seq_req, grant, step, accept;

    assign cur_addr = 5'(row) * 5'(NUM_COLS) + 5'(col);
    assign code     = ch_data[6:0];

    assign ch_ready = (state == IDLE) & ~rst;
    assign busy     = (state != IDLE);
    assign accept   = ch_valid & ch_ready;

    // A grant drives the port. The step only retires when the host is not
    // also writing; otherwise the same step is retried next cycle.
    assign grant = blank & seq_req;
    assign step  = grant & ~host_we;

    assign buf_we     = host_we | grant;
    assign buf_addr   = host_we ? host_addr  : seq_addr;
    assign buf_wdata  = host_we ? host_wdata : seq_data;
    assign cursor_row = row;
    assign cursor_col = col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            row    <= '0;
            col    <= '0;
            idx    <= '0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            row    <= row_n;
            col    <= col_n;
            idx    <= idx_n;
            data_q <= data_n;
        end
    end

    always_comb begin
        state_n   = state;
        row_n     = row;
        col_n     = col;
        idx_n     = idx;
        data_n    = data_q;
        seq_req   = 1'b0;
        seq_addr  = cur_addr;
        seq_data  = data_q;
        buf_raddr = cur_addr;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (code >= 7'h20 && code <= 7'h7E) begin
                        data_n  = ch_data;
                        state_n = PUT;
                    end else begin
                        case (code)
                            7'h0D: col_n = '0;
                            7'h0A: begin
                                col_n = '0;
                                if (row < 2'(NUM_ROWS - 1)) begin
                                    row_n = row + 2'd1;
                                end else begin
                                    idx_n   = '0;
                                    state_n = SCROLL_COPY;
                                end
                            end
                            7'h08: if (col != '0) col_n = col - 4'd1;
                            7'h0C: begin
                                idx_n   = '0;
                                state_n = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                seq_req = 1'b1;
                if (step) begin
                    if (col < 4'(NUM_COLS - 1)) begin
                        col_n   = col + 4'd1;
                        state_n = IDLE;
                    end else begin
                        col_n = '0;
                        if (row < 2'(NUM_ROWS - 1)) begin
                            row_n   = row + 2'd1;
                            state_n = IDLE;
                        end else begin
                            idx_n   = '0;
                            state_n = SCROLL_COPY;
                        end
                    end
                end
            end
            SCROLL_COPY: begin
                // Move each cell up one row. The read port is combinational,
                // so the source cell is fetched in the same cycle.
                seq_req   = 1'b1;
                buf_raddr = idx + 5'(NUM_COLS);
                seq_addr  = idx;
                seq_data  = buf_rdata;
                if (step) begin
                    idx_n = idx + 5'd1;
                    if (idx == 5'(LAST_COPY)) state_n = SCROLL_CLEAR;
                end
            end
            SCROLL_CLEAR, CLEAR: begin
                seq_req  = 1'b1;
                seq_addr = idx;
                seq_data = 8'h20;
                if (step) begin
                    idx_n = idx + 5'd1;
                    if (idx == 5'(LAST_CELL)) begin
                        state_n = IDLE;
                        if (state == CLEAR) begin
                            row_n = '0;
                            col_n = '0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_vgacon_term_ctrl.sv
// Self-checking bench for vgacon_term_ctrl. The bench owns a 30-cell text
// buffer and keeps a character-level terminal model of the screen contents
// and cursor position.
module tb_vgacon_term_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       ch_valid = 1'b0, ch_ready;
    logic [7:0] ch_data = '0;
    logic       host_we = 1'b0;
    logic [4:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       blank = 1'b1;
    logic       buf_we, busy;
    logic [4:0] buf_addr, buf_raddr;
    logic [7:0] buf_wdata, buf_rdata;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;

    vgacon_term_ctrl dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .blank(blank), .buf_we(buf_we),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_raddr(buf_raddr),
        .buf_rdata(buf_rdata), .cursor_row(cursor_row),
        .cursor_col(cursor_col), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- text buffer + write monitor ----------------
    typedef struct { logic host; logic [4:0] addr; logic [7:0] data; } wr_t;
    wr_t        wlog[$];
    logic [7:0] mem[32];
    bit         mem_init = 1'b0;
    int         viol = 0;

    assign buf_rdata = mem[buf_raddr];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            mem_init <= 1'b1;
        end else if (buf_we) begin
            mem[buf_addr] <= buf_wdata;
        end
        if (buf_we) wlog.push_back('{host_we, buf_addr, buf_wdata});
        if (buf_we && !host_we && !blank) viol++;
    end

    // blank: 0 = held high, 1 = random, 2 = toggle every 4 cycles
    int blank_mode = 0;
    int tog_cnt = 0;
    always @(negedge clk) begin
        if (blank_mode == 1) blank = (($urandom % 4) != 0);
        else if (blank_mode == 2) begin
            tog_cnt++;
            if (tog_cnt % 4 == 0) blank = ~blank;
        end else blank = 1'b1;
    end

    // ---------------- terminal reference model ----------------
    logic [7:0] screen[30];
    int mrow = 0, mcol = 0;

    function automatic void scroll_up();
        for (int i = 0; i < 20; i++) screen[i] = screen[i + 10];
        for (int i = 20; i < 30; i++) screen[i] = 8'h20;
    endfunction

    function automatic void apply(input logic [7:0] c);
        int k = int'(c[6:0]);
        if (k >= 32 && k <= 126) begin
            screen[mrow * 10 + mcol] = c;
            if (mcol < 9) mcol++;
            else begin
                mcol = 0;
                if (mrow < 2) mrow++; else scroll_up();
            end
        end else if (k == 13) mcol = 0;
        else if (k == 10) begin
            mcol = 0;
            if (mrow < 2) mrow++; else scroll_up();
        end else if (k == 8) begin
            if (mcol > 0) mcol--;
        end else if (k == 12) begin
            for (int i = 0; i < 30; i++) screen[i] = 8'h20;
            mrow = 0;
            mcol = 0;
        end
    endfunction

    // ---------------- checking helpers ----------------
    int pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string nm, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic check_screen(input string nm);
        int bad = 0;
        for (int i = 0; i < 30; i++) if (mem[i] !== screen[i]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic check_cursor(input string nm);
        chk({nm, "_row"}, int'(cursor_row), mrow);
        chk({nm, "_col"}, int'(cursor_col), mcol);
    endtask

    // All stimulus tasks start and end at a falling edge.
    task automatic send_ch(input logic [7:0] c);
        int t = 0;
        ch_valid = 1'b1;
        ch_data  = c;
        while (!ch_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!ch_ready) begin
            chk("send_timeout", 0, 1);
            ch_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            ch_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] c);
        send_ch(c);
        apply(c);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(posedge clk);
        @(negedge clk);
        host_we = 1'b0;
        screen[a] = d;
    endtask

    typedef struct { logic [7:0] ch; int er; int ec; } vec_t;
    vec_t vt[12];

    initial begin
        logic [7:0] pre[30];
        wr_t seq[$];
        wr_t hst[$];
        int bad, cnt, n;

        vt[0]  = '{8'h08, 0, 1};  vt[1]  = '{8'h78, 0, 2};
        vt[2]  = '{8'h0D, 0, 0};  vt[3]  = '{8'h0A, 1, 0};
        vt[4]  = '{8'h01, 1, 0};  vt[5]  = '{8'h7F, 1, 0};
        vt[6]  = '{8'h79, 1, 1};  vt[7]  = '{8'h0A, 2, 0};
        vt[8]  = '{8'h08, 2, 0};  vt[9]  = '{8'hFA, 2, 1};
        vt[10] = '{8'h0C, 0, 0};  vt[11] = '{8'h51, 0, 1};
        for (int i = 0; i < 30; i++) screen[i] = 8'h00;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(ch_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_we", int'(buf_we), 0);
        chk("rst_row", int'(cursor_row), 0);
        chk("rst_col", int'(cursor_col), 0);
        rst = 1'b0;
        #1 chk("rel_ready", int'(ch_ready), 1);
        @(negedge clk);

        // "HI": write one cycle after acceptance, ready the cycle after that
        send_ch(8'h48);
        chk("h_we", int'(buf_we), 1);
        chk("h_addr", int'(buf_addr), 0);
        chk("h_data", int'(buf_wdata), 8'h48);
        chk("h_busy_ready", int'(ch_ready), 0);
        apply(8'h48);
        @(negedge clk);
        chk("h_ready_after", int'(ch_ready), 1);
        send_ch(8'h49);
        chk("i_addr", int'(buf_addr), 1);
        chk("i_data", int'(buf_wdata), 8'h49);
        apply(8'h49);
        @(negedge clk);
        chk("i_ready_after", int'(ch_ready), 1);
        check_cursor("hi");

        // vector table
        foreach (vt[i]) begin
            send(vt[i].ch);
            wait_idle();
            chk($sformatf("vec%0d_row", i), int'(cursor_row), vt[i].er);
            chk($sformatf("vec%0d_col", i), int'(cursor_col), vt[i].ec);
        end
        check_screen("vec_screen");

        // line wrap and scroll on write past the last cell
        send(8'h0D);
        for (int i = 0; i < 9; i++) send(8'h61 + 8'(i));
        wait_idle();
        send(8'h41);
        wait_idle();
        chk("wrap_addr", int'(wlog[$].addr), 9);
        chk("wrap_data", int'(wlog[$].data), 8'h41);
        check_cursor("wrap");
        for (int i = 0; i < 19; i++) send(8'h6B + 8'(i % 10));
        wait_idle();
        check_cursor("pre_scroll");
        pre = screen;
        pre[29] = 8'h42;
        wlog.delete();
        send(8'h42);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("scroll_busy_cycles", cnt, 31);
        chk("scroll_nwrites", wlog.size(), 31);
        bad = 0;
        if (wlog.size() == 31) begin
            if (wlog[0].addr != 29 || wlog[0].data != 8'h42) bad++;
            for (int i = 0; i < 20; i++)
                if (wlog[1+i].addr != 5'(i) || wlog[1+i].data != pre[i+10]) bad++;
            for (int i = 0; i < 10; i++)
                if (wlog[21+i].addr != 5'(20+i) || wlog[21+i].data != 8'h20) bad++;
        end else bad = 1;
        chk("scroll_seq", bad, 0);
        check_screen("scroll_screen");
        check_cursor("scroll");

        // FF with blanking toggling
        blank_mode = 2;
        viol = 0;
        wlog.delete();
        send(8'h0C);
        wait_idle();
        blank_mode = 0;
        @(negedge clk);
        chk("ff_viol", viol, 0);
        chk("ff_nwrites", wlog.size(), 30);
        bad = 0;
        foreach (wlog[i]) if (wlog[i].addr != 5'(i) || wlog[i].data != 8'h20) bad++;
        chk("ff_seq", bad, 0);
        check_cursor("ff");

        // host writes interleaved with a scroll copy
        for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) send(8'h50 + 8'(i));
        for (int i = 0; i < 5; i++) send(8'h70 + 8'(i));
        wait_idle();
        send(8'h0D);
        pre = screen;
        wlog.delete();
        send_ch(8'h0A);
        apply(8'h0A);
        for (int k = 0; k < 36; k++) begin
            host_we = (k % 2 == 0);
            host_addr = 5'd3;
            host_wdata = 8'h7F;
            @(negedge clk);
        end
        host_we = 1'b0;
        screen[3] = 8'h7F;
        wait_idle();
        seq.delete();
        hst.delete();
        foreach (wlog[i]) if (wlog[i].host) hst.push_back(wlog[i]); else seq.push_back(wlog[i]);
        chk("hst_count", hst.size(), 18);
        bad = 0;
        foreach (hst[i]) if (hst[i].addr != 3 || hst[i].data != 8'h7F) bad++;
        chk("hst_data", bad, 0);
        chk("hseq_count", seq.size(), 30);
        bad = 0;
        n = (seq.size() < 20) ? seq.size() : 20;
        for (int i = 0; i < n; i++)
            if (seq[i].addr != 5'(i) || seq[i].data != pre[i+10]) bad++;
        chk("hseq_copy_order", bad, 0);
        check_screen("host_screen");
        check_cursor("host");

        // BS/CR at (1,0), LF at (1,5)
        send(8'h0C);
        wait_idle();
        send(8'h0A);
        n = wlog.size();
        send(8'h08);
        chk("bs_ready", int'(ch_ready), 1);
        send(8'h0D);
        chk("cr_ready", int'(ch_ready), 1);
        check_cursor("bscr");
        chk("bscr_nowrite", wlog.size(), n);
        for (int i = 0; i < 5; i++) send(8'h2A);
        wait_idle();
        send(8'h0A);
        chk("lf_ready", int'(ch_ready), 1);
        chk("lf_busy", int'(busy), 0);
        check_cursor("lf");

        // reset during scroll copy at idx 7
        pre = screen;
        wlog.delete();
        send_ch(8'h0A);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", int'(buf_we), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(ch_ready), 0);
        mrow = 0;
        mcol = 0;
        check_cursor("mid_rst");
        for (int i = 0; i < 7; i++) screen[i] = pre[i+10];
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_hold_ready", int'(ch_ready), 0);
        chk("mid_rst_nwrites", wlog.size(), 7);
        rst = 1'b0;
        #1 chk("mid_rel_ready", int'(ch_ready), 1);
        @(negedge clk);
        check_screen("mid_rst_screen");

        // randomized traffic against the model
        blank_mode = 1;
        viol = 0;
        for (int op = 0; op < 150; op++) begin
            int r = $urandom % 20;
            if (r < 3) host_write(5'($urandom % 30), 8'($urandom));
            else if (r < 12) send(8'(32 + $urandom % 95) | (($urandom % 2) ? 8'h80 : 8'h00));
            else if (r < 13) send(8'h0D);
            else if (r < 16) send(8'h0A);
            else if (r < 17) send(8'h08);
            else if (r < 18) send(($urandom % 3 == 0) ? 8'h0C : 8'h5F);
            else send(($urandom % 2) ? 8'h7F : 8'h05);
            wait_idle();
            check_cursor($sformatf("rnd%0d", op));
            check_screen($sformatf("rnd%0d_screen", op));
        end
        blank_mode = 0;
        chk("rnd_viol", viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
